// File: rtl/mb_arbiter_if.sv
// Request/response bundle shared by the two upstream ports and the downstream port of mb_arbiter.
// The master modport issues requests; the slave modport answers them.
`ifndef RW
`define RW 16
`endif

interface mb_arbiter_if;
    logic [`RW-1:0] req_addr;
    logic           req_active;
    logic           req_next;
    logic [`RW-1:0] req_data;
    logic           req_data_valid;

    modport master (
        output req_addr, req_active, req_next,
        input  req_data, req_data_valid
    );

    modport slave (
        input  req_addr, req_active, req_next,
        output req_data, req_data_valid
    );
endinterface

// File: rtl/mb_arbiter.sv
// Two-port memory bus arbiter: port 0 (instruction fetch) and port 1 (data) share one downstream bus.
// Define MB_ARB_RR_EN for round-robin conflict resolution; fixed port-0 priority otherwise.
`ifndef RW
`define RW 16
`endif

module mb_arbiter (
    input  logic              i_clk,
    input  logic              i_rst,
    mb_arbiter_if.slave       m0,
    mb_arbiter_if.slave       m1,
    mb_arbiter_if.master      d,
    output logic [1:0]        o_grant
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] GRANT0 = 2'd1;
    localparam logic [1:0] GRANT1 = 2'd2;

    logic [1:0] state_q, state_d;
    logic       pick1;

`ifdef MB_ARB_RR_EN
    // last_q set means port 1 owned the bus most recently
    logic last_q, last_d;

    assign pick1 = m1.req_active && (!m0.req_active || !last_q);

    always_comb begin
        last_d = last_q;
        if (state_q == IDLE && state_d != IDLE) begin
            last_d = (state_d == GRANT1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`else
    assign pick1 = m1.req_active && !m0.req_active;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (m0.req_active || m1.req_active) begin
                    state_d = pick1 ? GRANT1 : GRANT0;
                end
            end
            GRANT0: begin
                if (!m0.req_active || (d.req_data_valid && !m0.req_next)) begin
                    state_d = IDLE;
                end
            end
            GRANT1: begin
                if (!m1.req_active || (d.req_data_valid && !m1.req_next)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign m0.req_data = d.req_data;
    assign m1.req_data = d.req_data;

    always_comb begin
        d.req_addr        = '0;
        d.req_active      = 1'b0;
        d.req_next        = 1'b0;
        m0.req_data_valid = 1'b0;
        m1.req_data_valid = 1'b0;
        o_grant           = 2'b00;
        case (state_q)
            GRANT0: begin
                d.req_addr        = m0.req_addr;
                d.req_active      = m0.req_active;
                d.req_next        = m0.req_next;
                m0.req_data_valid = d.req_data_valid;
                o_grant           = 2'b01;
            end
            GRANT1: begin
                d.req_addr        = m1.req_addr;
                d.req_active      = m1.req_active;
                d.req_next        = m1.req_next;
                m1.req_data_valid = d.req_data_valid;
                o_grant           = 2'b10;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mb_arbiter.sv
// Scoreboard bench for mb_arbiter: a transaction-level model predicts grant order and beats,
// a monitor compares them whenever the DUT grants or forwards a valid.
module tb_mb_arbiter;

`ifdef MB_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    localparam logic [15:0] KEY = 16'h5A3C;

    typedef struct {
        logic [15:0] base;
        int unsigned len;
    } txn_t;

    typedef struct {
        int unsigned port;
        logic [15:0] addr;
        logic [15:0] data;
    } beat_t;

    logic       clk;
    logic       rst;
    logic [1:0] grant;

    mb_arbiter_if m0_bus ();
    mb_arbiter_if m1_bus ();
    mb_arbiter_if d_bus ();

    mb_arbiter dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .m0      (m0_bus),
        .m1      (m1_bus),
        .d       (d_bus),
        .o_grant (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    beat_t       bq[$];
    int unsigned gq[$];
    int unsigned model_last = 1;

    txn_t        plan[2][4];
    int unsigned ntx[2];
    int unsigned tx_i[2];
    int unsigned beat[2];
    logic        done[2];
    logic        drv_en = 1'b0;
    int unsigned rsp_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_m(input int unsigned p, input logic a, input logic [15:0] ad, input logic n);
        if (p == 0) begin
            m0_bus.req_active = a; m0_bus.req_addr = ad; m0_bus.req_next = n;
        end else begin
            m1_bus.req_active = a; m1_bus.req_addr = ad; m1_bus.req_next = n;
        end
    endtask

    // Reference: every pending port keeps requesting; each arbitration picks by the priority rule.
    task automatic model_round();
        int unsigned i[2];
        int unsigned w;
        i[0] = 0; i[1] = 0;
        while (i[0] < ntx[0] || i[1] < ntx[1]) begin
            if (i[0] < ntx[0] && i[1] < ntx[1]) w = (RR && model_last == 0) ? 1 : 0;
            else w = (i[0] < ntx[0]) ? 0 : 1;
            gq.push_back(w);
            for (int unsigned b = 0; b < plan[w][i[w]].len; b++) begin
                logic [15:0] a;
                a = plan[w][i[w]].base + 16'(b);
                bq.push_back('{port: w, addr: a, data: a ^ KEY});
            end
            model_last = w;
            i[w]++;
        end
    endtask

    // Masters and downstream responder, active only during scheduled rounds
    initial forever begin
        @(negedge clk);
        done[0] = m0_bus.req_data_valid;
        done[1] = m1_bus.req_data_valid;
        @(posedge clk);
        #1;
        if (drv_en) begin
            for (int unsigned p = 0; p < 2; p++) begin
                if (done[p] && tx_i[p] < ntx[p]) begin
                    beat[p]++;
                    if (beat[p] == plan[p][tx_i[p]].len) begin
                        tx_i[p]++;
                        beat[p] = 0;
                    end
                end
                if (tx_i[p] < ntx[p])
                    set_m(p, 1'b1, plan[p][tx_i[p]].base + 16'(beat[p]),
                          beat[p] + 1 < plan[p][tx_i[p]].len);
                else
                    set_m(p, 1'b0, 16'h0000, 1'b0);
            end
        end
        #1;
        if (drv_en) begin
            d_bus.req_data_valid = 1'b0;
            if (d_bus.req_active) begin
                if (rsp_cnt == 0) begin
                    d_bus.req_data_valid = 1'b1;
                    d_bus.req_data       = d_bus.req_addr ^ KEY;
                    rsp_cnt              = $urandom_range(0, 2);
                end else begin
                    rsp_cnt--;
                end
            end
        end
    end

    // Monitor: checks each new grant and each forwarded beat against the queues
    logic [1:0] prev_grant = 2'b00;
    initial forever begin
        @(negedge clk);
        if (grant == 2'b11) chk("grant_onehot", {30'd0, grant}, 32'd0);
        if (grant != 2'b00 && prev_grant == 2'b00) begin
            if (gq.size() == 0) begin
                chk("grant_unexpected", {30'd0, grant}, 32'd0);
            end else begin
                int unsigned e;
                e = gq.pop_front();
                chk("grant", {30'd0, grant}, (e == 0) ? 32'd1 : 32'd2);
            end
        end
        prev_grant = grant;
        if (m0_bus.req_data_valid || m1_bus.req_data_valid) begin
            if (bq.size() == 0) begin
                chk("valid_unexpected", {30'd0, m1_bus.req_data_valid, m0_bus.req_data_valid}, 32'd0);
            end else begin
                beat_t e;
                e = bq.pop_front();
                chk("beat_port", {30'd0, m1_bus.req_data_valid, m0_bus.req_data_valid},
                    (e.port == 0) ? 32'd1 : 32'd2);
                chk("beat_addr", {16'd0, d_bus.req_addr}, {16'd0, e.addr});
                chk("beat_data", {16'd0, (e.port == 0) ? m0_bus.req_data : m1_bus.req_data},
                    {16'd0, e.data});
            end
        end
    end

    task automatic run_round();
        tx_i[0] = 0; tx_i[1] = 0; beat[0] = 0; beat[1] = 0;
        model_round();
        drv_en = 1'b1;
        for (int c = 0; c < 400 && !(tx_i[0] >= ntx[0] && tx_i[1] >= ntx[1]); c++)
            @(posedge clk);
        chk("round_complete", {31'd0, tx_i[0] >= ntx[0] && tx_i[1] >= ntx[1]}, 32'd1);
        repeat (2) @(posedge clk);
        drv_en = 1'b0;
        d_bus.req_data_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        set_m(0, 1'b0, 16'h0, 1'b0);
        set_m(1, 1'b0, 16'h0, 1'b0);
        d_bus.req_data = 16'h0;
        d_bus.req_data_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_grant", {30'd0, grant}, 32'd0);
        chk("reset_dact", {31'd0, d_bus.req_active}, 32'd0);
        chk("reset_daddr", {16'd0, d_bus.req_addr}, 32'd0);

        // Single read with one-cycle grant latency
        @(posedge clk); #1;
        set_m(0, 1'b1, 16'h0010, 1'b0);
        gq.push_back(0); model_last = 0;
        @(negedge clk);
        chk("lat_grant_idle", {30'd0, grant}, 32'd0);
        chk("lat_dact_idle", {31'd0, d_bus.req_active}, 32'd0);
        @(negedge clk);
        chk("lat_dact", {31'd0, d_bus.req_active}, 32'd1);
        chk("lat_daddr", {16'd0, d_bus.req_addr}, 32'h10);
        @(posedge clk); #1;
        d_bus.req_data = 16'hBEEF; d_bus.req_data_valid = 1'b1;
        bq.push_back('{port: 0, addr: 16'h0010, data: 16'hBEEF});
        @(posedge clk); #1;
        d_bus.req_data_valid = 1'b0;
        set_m(0, 1'b0, 16'h0, 1'b0);
        @(negedge clk);
        chk("done_idle", {30'd0, grant}, 32'd0);

        // Abort on port 1, then a late valid in IDLE must be dropped
        @(posedge clk); #1;
        set_m(1, 1'b1, 16'h0033, 1'b0);
        gq.push_back(1); model_last = 1;
        @(negedge clk); @(negedge clk);
        chk("abort_dact", {31'd0, d_bus.req_active}, 32'd1);
        @(posedge clk); #1;
        set_m(1, 1'b0, 16'h0033, 1'b0);
        @(posedge clk); #1;
        d_bus.req_data = 16'h1234; d_bus.req_data_valid = 1'b1;
        @(negedge clk);
        chk("abort_idle", {30'd0, grant}, 32'd0);
        chk("late_valid_m0", {31'd0, m0_bus.req_data_valid}, 32'd0);
        chk("late_valid_m1", {31'd0, m1_bus.req_data_valid}, 32'd0);
        @(posedge clk); #1;
        d_bus.req_data_valid = 1'b0;

        // Reset during beat 1 of an m0 burst, then a fresh m1 request
        @(posedge clk); #1;
        set_m(0, 1'b1, 16'h0040, 1'b1);
        gq.push_back(0); model_last = 0;
        @(negedge clk); @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        d_bus.req_data = 16'h4444; d_bus.req_data_valid = 1'b1;
        @(negedge clk);
        chk("rst_grant", {30'd0, grant}, 32'd0);
        chk("rst_dact", {31'd0, d_bus.req_active}, 32'd0);
        chk("rst_m0_valid", {31'd0, m0_bus.req_data_valid}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; d_bus.req_data_valid = 1'b0;
        set_m(0, 1'b0, 16'h0, 1'b0);
        model_last = 1;
        @(posedge clk); #1;
        set_m(1, 1'b1, 16'h0055, 1'b0);
        gq.push_back(1); model_last = 1;
        @(negedge clk); @(negedge clk);
        @(posedge clk); #1;
        d_bus.req_data = 16'h7777; d_bus.req_data_valid = 1'b1;
        bq.push_back('{port: 1, addr: 16'h0055, data: 16'h7777});
        @(posedge clk); #1;
        d_bus.req_data_valid = 1'b0;
        set_m(1, 1'b0, 16'h0, 1'b0);
        repeat (2) @(posedge clk);

        // Two-beat m0 burst while m1 waits
        ntx[0] = 1; ntx[1] = 1;
        plan[0][0] = '{base: 16'h0020, len: 2};
        plan[1][0] = '{base: 16'h0900, len: 1};
        run_round();

        // Both ports continuously active for four transactions
        ntx[0] = 2; ntx[1] = 2;
        for (int unsigned k = 0; k < 2; k++) begin
            plan[0][k] = '{base: 16'h0100 + 16'(k * 16), len: 1};
            plan[1][k] = '{base: 16'h0200 + 16'(k * 16), len: 1};
        end
        run_round();

        for (int r = 0; r < 25; r++) begin
            int unsigned pat;
            pat = $urandom_range(1, 3);
            for (int unsigned p = 0; p < 2; p++) begin
                ntx[p] = pat[p] ? $urandom_range(1, 2) : 0;
                for (int unsigned k = 0; k < 4; k++)
                    plan[p][k] = '{base: 16'($urandom), len: $urandom_range(1, 3)};
            end
            run_round();
        end

        chk("beats_left", bq.size(), 32'd0);
        chk("grants_left", gq.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
